// File: rtl/tt_um_mascarenhas_tff_bank.sv
// Bank of WIDTH T flip-flops behind a pin synchroniser.
// The mode field picks level toggle, edge toggle, chained counter or direct load.
// Flags on the upper uio pins: wrap pulse, nonzero and parity of q.

// Next-state logic for a single channel. The counter chain passes
// cnt_en = t_s[0] & q[0] & ... & q[i-1] from lane to lane.
module tff_lane (
    input  logic [1:0] mode,
    input  logic       q,
    input  logic       t,
    input  logic       t_prev,
    input  logic       cnt_en,
    output logic       q_nxt,
    output logic       cnt_en_out
);
    assign cnt_en_out = cnt_en & q;

    // Pick the next value of this bit from the active mode.
    always_comb begin
        case (mode)
            2'b00:   q_nxt = q ^ t;
            2'b01:   q_nxt = q ^ (t & ~t_prev);
            2'b10:   q_nxt = q ^ cnt_en;
            default: q_nxt = t;
        endcase
    end
endmodule

module tt_um_mascarenhas_tff_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [SYNC_STAGES-1:0][7:0] t_sync;
    logic [SYNC_STAGES-1:0][3:0] c_sync;
    logic [7:0]       t_s;
    logic [3:0]       c_s;
    logic [1:0]       mode;
    logic             hold;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] t_d;
    logic [WIDTH:0]   chain;
    logic             wrap;
    logic             wrap_nxt;

    // Synchroniser chains for the T pins and the control nibble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_sync <= '0;
            c_sync <= '0;
        end else begin
            t_sync[0] <= ui_in;
            c_sync[0] <= uio_in[3:0];
            for (int s = 1; s < SYNC_STAGES; s++) begin
                t_sync[s] <= t_sync[s-1];
                c_sync[s] <= c_sync[s-1];
            end
        end
    end

    assign t_s  = t_sync[SYNC_STAGES-1];
    assign c_s  = c_sync[SYNC_STAGES-1];
    assign mode = c_s[1:0];
    assign hold = c_s[2];
    assign clr  = c_s[3];

    // Counter enable enters at lane 0 from channel 0's T input only.
    assign chain[0] = t_s[0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        tff_lane u_lane (
            .mode       (mode),
            .q          (q[i]),
            .t          (t_s[i]),
            .t_prev     (t_d[i]),
            .cnt_en     (chain[i]),
            .q_nxt      (q_nxt[i]),
            .cnt_en_out (chain[i+1])
        );
    end

    // A carry out of the top lane means q was all-ones and is wrapping to 0.
    assign wrap_nxt = (mode == 2'b10) & chain[WIDTH];

    // State update: clear beats hold beats mode action; t_d always tracks so
    // entering edge mode never sees a stale level as a rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= '0;
            wrap <= 1'b0;
            t_d  <= '0;
        end else begin
            t_d <= t_s[WIDTH-1:0];
            if (clr) begin
                q    <= '0;
                wrap <= 1'b0;
            end else if (hold) begin
                wrap <= 1'b0;
            end else begin
                q    <= q_nxt;
                wrap <= wrap_nxt;
            end
        end
    end

    // Zero-extend q onto the output pins.
    always_comb begin
        uo_out          = '0;
        uo_out[WIDTH-1:0] = q;
    end

    assign uio_out = {1'b0, ^q, |q, wrap, 4'b0000};
    assign uio_oe  = 8'hF0;

    logic unused;
    assign unused = &{1'b0, ena, uio_in[7:4], t_s};
endmodule
